ps2_key_ctrl: RTL and testbench

- Scan-code controller behind the PS/2 byte receiver.
- Consumes received bytes with their ready/error flags, and decodes set-2 prefixes (E0 = extended, F0 = break) into single key events.
- Queues events in a small FIFO read by the host logic through a valid/ready handshake.
- Counts line errors and prefix timeouts for debug.

---
 rtl/ps2_key_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl
// Scan-code controller that sits behind a PS/2 byte receiver. It decodes the
// set-2 prefixes (E0 = extended, F0 = break) into single key events. Events go
// into a small FIFO that the host drains through a valid/ready handshake.
// Line errors, overrun codes and prefix timeouts are counted for debug.
//
// Ports
//   clk       system clock, all logic on posedge
//   rst       synchronous active-high reset
//   rx_data   received byte, stable while rx_ready is high
//   rx_ready  receiver frame-done level (asynchronous to clk); a rising edge marks a new byte
//   rx_error  receiver error flag, valid with rx_ready
//   ev_valid  FIFO not empty
//   ev_data   {extended, released, code[7:0]} at the FIFO head
//   ev_ready  host pop; a pop happens when ev_valid & ev_ready
//   overflow  sticky flag: an event was dropped because the FIFO was full
//   clr       clears overflow and err_cnt
//   err_cnt   saturating count of error bytes, overrun codes and timeouts
module ps2_key_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       rx_error,
    output logic       ev_valid,
    output logic [9:0] ev_data,
    input  logic       ev_ready,
    output logic       overflow,
    input  logic       clr,
    output logic [7:0] err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    // ------------------------------------------------------------------
    // Input capture: two-flop synchronizer plus rising-edge detect
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       prev_q;
    logic       strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx_ready};
            prev_q <= sync_q[1];
        end
    end

    assign strobe = sync_q[1] & ~prev_q;

    // ------------------------------------------------------------------
    // Prefix decoder
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [TW-1:0]   tmo_q;
    logic            push_q;
    logic [9:0]      push_data_q;
    logic [7:0]      err_cnt_q;
    logic            bad_code;
    logic            tmo_hit;
    logic            err_hit;

    assign bad_code = (rx_data == 8'h00) || (rx_data == 8'hFF);
    // A strobe on the same cycle as the last timeout count takes priority.
    assign tmo_hit  = ~strobe && (state_q != S_IDLE) && (tmo_q == TMO_LAST);

    always_comb begin
        err_hit = 1'b0;
        if (strobe)
            err_hit = rx_error | bad_code;
        else
            err_hit = tmo_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= 10'd0;
            err_cnt_q   <= 8'd0;
        end else begin
            push_q <= 1'b0;
            if (strobe) begin
                tmo_q <= '0;
                if (rx_error || bad_code) begin
                    state_q <= S_IDLE;
                end else begin
                    unique case (state_q)
                        S_IDLE: begin
                            if (rx_data == 8'hE0)      state_q <= S_EXT;
                            else if (rx_data == 8'hF0) state_q <= S_BRK;
                            else begin
                                push_q      <= 1'b1;
                                push_data_q <= {2'b00, rx_data};
                            end
                        end
                        S_EXT: begin
                            if (rx_data == 8'hF0)      state_q <= S_EXT_BRK;
                            else if (rx_data == 8'hE0) state_q <= S_EXT;
                            else begin
                                push_q      <= 1'b1;
                                push_data_q <= {2'b10, rx_data};
                                state_q     <= S_IDLE;
                            end
                        end
                        S_BRK: begin
                            // A late E0 after F0 is treated as an ordinary code.
                            if (rx_data == 8'hF0) state_q <= S_BRK;
                            else begin
                                push_q      <= 1'b1;
                                push_data_q <= {2'b01, rx_data};
                                state_q     <= S_IDLE;
                            end
                        end
                        S_EXT_BRK: begin
                            if (rx_data == 8'hF0 || rx_data == 8'hE0) state_q <= S_EXT_BRK;
                            else begin
                                push_q      <= 1'b1;
                                push_data_q <= {2'b11, rx_data};
                                state_q     <= S_IDLE;
                            end
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end else if (state_q != S_IDLE) begin
                if (tmo_hit) begin
                    state_q <= S_IDLE;
                    tmo_q   <= '0;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end else begin
                tmo_q <= '0;
            end

            // clr wins over a same-cycle increment.
            if (clr)
                err_cnt_q <= 8'd0;
            else if (err_hit && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [9:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          full;
    logic          pop;
    logic          do_push;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = (count_q != '0) & ev_ready;
    // When full, a same-cycle pop frees the slot, so nothing is dropped.
    assign do_push = push_q & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_q] <= push_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (pop)     rd_q <= rd_q + AW'(1);
            unique case ({do_push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (clr)
                overflow_q <= 1'b0;
            else if (push_q && !do_push)
                overflow_q <= 1'b1;
        end
    end

    assign ev_valid = (count_q != '0);
    assign ev_data  = mem_q[rd_q];
    assign overflow = overflow_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
module tb_ps2_key_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 100;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_error;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       ev_ready;
    logic       overflow;
    logic       clr;
    logic [7:0] err_cnt;

    ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_error (rx_error),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_ready (ev_ready),
        .overflow (overflow),
        .clr      (clr),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [9:0] got[$];
    logic [9:0] expq[$];

    // Popped events are recorded away from the active edge.
    always @(negedge clk) begin
        if (ev_valid && ev_ready) got.push_back(ev_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic e, input int hold, input int low);
        @(posedge clk); #1;
        rx_data  = b;
        rx_error = e;
        rx_ready = 1'b1;
        repeat (hold) @(posedge clk);
        #1 rx_ready = 1'b0;
        repeat (low) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic drain(input int n);
        @(posedge clk); #1 ev_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1 ev_ready = 1'b0;
        @(negedge clk);
    endtask

    // Compare popped events against expq, then clear both.
    task automatic cmp_events(input string name);
        chk({name, "_n"}, 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk({name, "_ev"}, 32'(got[i]), 32'(expq[i]));
        got.delete();
        expq.delete();
    endtask

    // Behavioural reference: two prefix flags, applied byte by byte.
    logic m_ext, m_brk;
    int   m_err;

    task automatic model_byte(input logic [7:0] b, input logic e);
        if (e || b == 8'h00 || b == 8'hFF) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0 && (!m_brk || m_ext)) begin
            m_ext = 1'b1;
        end else begin
            expq.push_back({m_ext, m_brk, b});
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] b;
        logic       e;
        logic       has;
        logic [9:0] ev;
        logic [7:0] err;
    } vec_t;

    vec_t vt[26];
    logic rdone;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 8'd0};
        vt[1]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 8'd0};
        vt[2]  = '{8'h1C, 1'b0, 1'b1, 10'h11C, 8'd0};
        vt[3]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 8'd0};
        vt[4]  = '{8'h75, 1'b0, 1'b1, 10'h275, 8'd0};
        vt[5]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 8'd0};
        vt[6]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 8'd0};
        vt[7]  = '{8'h75, 1'b0, 1'b1, 10'h375, 8'd0};
        vt[8]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 8'd0};
        vt[9]  = '{8'h1C, 1'b1, 1'b0, 10'h000, 8'd1};
        vt[10] = '{8'h1C, 1'b0, 1'b1, 10'h01C, 8'd1};
        vt[11] = '{8'h00, 1'b0, 1'b0, 10'h000, 8'd2};
        vt[12] = '{8'hF0, 1'b0, 1'b0, 10'h000, 8'd2};
        vt[13] = '{8'hE0, 1'b0, 1'b1, 10'h1E0, 8'd2};
        vt[14] = '{8'hE0, 1'b0, 1'b0, 10'h000, 8'd2};
        vt[15] = '{8'hE0, 1'b0, 1'b0, 10'h000, 8'd2};
        vt[16] = '{8'h14, 1'b0, 1'b1, 10'h214, 8'd2};
        vt[17] = '{8'hE0, 1'b0, 1'b0, 10'h000, 8'd2};
        vt[18] = '{8'hF0, 1'b0, 1'b0, 10'h000, 8'd2};
        vt[19] = '{8'hE0, 1'b0, 1'b0, 10'h000, 8'd2};
        vt[20] = '{8'hF0, 1'b0, 1'b0, 10'h000, 8'd2};
        vt[21] = '{8'h11, 1'b0, 1'b1, 10'h311, 8'd2};
        vt[22] = '{8'hFF, 1'b0, 1'b0, 10'h000, 8'd3};
        vt[23] = '{8'hE0, 1'b0, 1'b0, 10'h000, 8'd3};
        vt[24] = '{8'hFF, 1'b0, 1'b0, 10'h000, 8'd4};
        vt[25] = '{8'h6B, 1'b0, 1'b1, 10'h06B, 8'd4};

        rst = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; rx_error = 1'b0;
        ev_ready = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ev_valid", 32'(ev_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);

        // Latency: first sampled high at edge k, ev_valid after edge k+3.
        @(posedge clk); #1 rx_data = 8'h5A; rx_error = 1'b0; rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lat_k2_valid", 32'(ev_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_k3_valid", 32'(ev_valid), 32'd1);
        chk("lat_k3_data", 32'(ev_data), 32'h05A);
        #1 rx_ready = 1'b0;
        drain(2);
        expq.push_back(10'h05A);
        cmp_events("lat_pop");

        // Table-driven decode vectors.
        @(posedge clk); #1 ev_ready = 1'b1;
        for (int i = 0; i < 26; i++) begin
            send(vt[i].b, vt[i].e, 3, 3);
            @(negedge clk);
            chk($sformatf("tbl%0d_n", i), 32'(got.size()), vt[i].has ? 32'd1 : 32'd0);
            if (vt[i].has && got.size() > 0)
                chk($sformatf("tbl%0d_ev", i), 32'(got[0]), 32'(vt[i].ev));
            chk($sformatf("tbl%0d_err", i), 32'(err_cnt), 32'(vt[i].err));
            got.delete();
        end
        pulse_clr();
        @(negedge clk);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);

        // Held level yields one strobe.
        send(8'h2A, 1'b0, 20, 3);
        @(negedge clk);
        expq.push_back(10'h02A);
        cmp_events("hold20");

        // Prefix timeout.
        send(8'hF0, 1'b0, 3, 3);
        repeat (80) @(posedge clk);
        @(negedge clk);
        chk("tmo_early_err", 32'(err_cnt), 32'd0);
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("tmo_err", 32'(err_cnt), 32'd1);
        chk("tmo_noev", 32'(got.size()), 32'd0);
        send(8'h1C, 1'b0, 3, 3);
        @(negedge clk);
        expq.push_back(10'h01C);
        cmp_events("tmo_after");

        // Overflow with nine codes and no pops.
        @(posedge clk); #1 ev_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) send(8'(8'h10 + i), 1'b0, 3, 3);
        @(negedge clk);
        chk("ovf_valid", 32'(ev_valid), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain(12);
        for (int i = 0; i < DEPTH; i++) expq.push_back(10'(10'h010 + i));
        cmp_events("ovf_pop");
        pulse_clr();
        @(negedge clk);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO with push and pop on the same cycle.
        for (int i = 0; i < DEPTH; i++) send(8'(8'h30 + i), 1'b0, 3, 3);
        @(negedge clk);
        chk("full_noovf", 32'(overflow), 32'd0);
        @(posedge clk); #1 rx_data = 8'h20; rx_error = 1'b0; rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 ev_ready = 1'b1;
        @(posedge clk);
        #1 ev_ready = 1'b0; rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pp_overflow", 32'(overflow), 32'd0);
        chk("pp_popped_n", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("pp_popped", 32'(got[0]), 32'h030);
        got.delete();
        drain(12);
        for (int i = 1; i < DEPTH; i++) expq.push_back(10'(10'h030 + i));
        expq.push_back(10'h020);
        cmp_events("pp_drain");

        // err_cnt saturation.
        for (int i = 0; i < 260; i++) send(8'h00, 1'b0, 2, 2);
        @(negedge clk);
        chk("sat_err", 32'(err_cnt), 32'd255);
        pulse_clr();
        @(negedge clk);
        chk("sat_clr", 32'(err_cnt), 32'd0);

        // Randomized traffic against the reference model.
        m_ext = 1'b0; m_brk = 1'b0; m_err = 0; rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [7:0] b;
                    logic       e;
                    int         r;
                    r = int'($urandom_range(15));
                    if (r < 3)       b = 8'hE0;
                    else if (r < 6)  b = 8'hF0;
                    else if (r == 6) b = ($urandom_range(1) == 0) ? 8'h00 : 8'hFF;
                    else             b = 8'($urandom_range(254, 1));
                    e = ($urandom_range(15) == 0);
                    model_byte(b, e);
                    send(b, e, 3, 3);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk); #1 ev_ready = ($urandom_range(3) != 0);
                end
            end
        join
        drain(20);
        cmp_events("rand");
        chk("rand_err", 32'(err_cnt), 32'(m_err));
        chk("rand_ovf", 32'(overflow), 32'd0);

        // Reset mid-EXT with a queued event and nonzero err_cnt.
        send(8'h1C, 1'b0, 3, 3);
        send(8'h00, 1'b0, 3, 3);
        send(8'hE0, 1'b0, 3, 3);
        @(negedge clk);
        chk("prerst_valid", 32'(ev_valid), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(ev_valid), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_err", 32'(err_cnt), 32'd0);
        got.delete();
        @(posedge clk); #1 ev_ready = 1'b1;
        send(8'h75, 1'b0, 3, 3);
        @(negedge clk);
        expq.push_back(10'h075);
        cmp_events("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
